// File: rtl/uart_boot_loader.sv
// Boot sequencer: receives an A5/len/data/checksum frame over UART, writes the image
// into program memory, acknowledges with ACK/NAK and releases the CPU on success.
module uart_boot_loader #(
  parameter int ADDR_W        = 8,
  parameter int INSTR_W       = 16,
  parameter bit HOLD_AT_RESET = 1'b1,
  parameter int TIMEOUT       = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               boot_done,
  output logic               boot_error,
  output logic               busy
);

  localparam int BYTES = INSTR_W / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CODE_ACK  = 8'h06;
  localparam logic [7:0] CODE_NAK  = 8'h15;

  typedef enum logic [2:0] {S_SYNC, S_LEN, S_DATA, S_CHECK, S_ACK} state_e;

  state_e             state_q, state_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         widx_q, widx_d;
  logic [BCW-1:0]     bcnt_q, bcnt_d;
  logic [INSTR_W-1:0] word_q, word_d;
  logic [7:0]         csum_q, csum_d;
  logic [31:0]        tmo_q, tmo_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         code_q, code_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic               last_byte, last_word, tmo_fire, in_frame;
  logic [INSTR_W-1:0] word_next;

  assign last_byte = (bcnt_q == BCW'(BYTES - 1));
  assign last_word = ((widx_q + 8'd1) == len_q);
  assign word_next = INSTR_W'({word_q, rx_data});
  assign in_frame  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK);
  // A byte arriving in the same cycle the counter expires wins over the timeout.
  assign tmo_fire  = (TIMEOUT != 0) && in_frame && !rx_valid && (tmo_q == 32'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_SYNC;
      len_q      <= '0;
      widx_q     <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      tx_valid_q <= 1'b0;
      code_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= HOLD_AT_RESET;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      widx_q     <= widx_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      tx_valid_q <= tx_valid_d;
      code_q     <= code_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC:  if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN;
      S_LEN: begin
        if (rx_valid)      state_d = (rx_data == 8'd0) ? S_CHECK : S_DATA;
        else if (tmo_fire) state_d = S_ACK;
      end
      S_DATA: begin
        if (rx_valid && last_byte && last_word) state_d = S_CHECK;
        else if (tmo_fire)                      state_d = S_ACK;
      end
      S_CHECK: if (rx_valid || tmo_fire) state_d = S_ACK;
      S_ACK:   if (tx_ready) state_d = S_SYNC;
      default: state_d = S_SYNC;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    widx_d     = widx_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    tmo_d      = 32'd0;
    tx_valid_d = tx_valid_q;
    code_d     = code_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_d      = err_q;
    busy_d     = (state_d != S_SYNC);

    // Counter holds the number of cycles since the last received byte.
    if (state_d == S_LEN || state_d == S_DATA || state_d == S_CHECK)
      tmo_d = rx_valid ? 32'd1 : tmo_q + 32'd1;

    case (state_q)
      S_SYNC: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          hold_d = 1'b1;
          err_d  = 1'b0;
          widx_d = '0;
          bcnt_d = '0;
          csum_d = '0;
        end
      end
      S_LEN: begin
        if (rx_valid) len_d = rx_data;
      end
      S_DATA: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          word_d = word_next;
          if (last_byte) begin
            bcnt_d  = '0;
            we_d    = 1'b1;
            addr_d  = ADDR_W'(widx_q);
            wdata_d = word_next;
            widx_d  = widx_q + 8'd1;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          code_d     = (rx_data == csum_q) ? CODE_ACK : CODE_NAK;
          err_d      = (rx_data != csum_q);
          tx_valid_d = 1'b1;
        end
      end
      S_ACK: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (code_q == CODE_ACK) begin
            hold_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (tmo_fire) begin
      code_d     = CODE_NAK;
      err_d      = 1'b1;
      tx_valid_d = 1'b1;
    end
  end

  always_comb begin
    tx_valid   = tx_valid_q;
    tx_data    = code_q;
    mem_we     = we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    cpu_hold   = hold_q;
    boot_done  = done_q;
    boot_error = err_q;
    busy       = busy_q;
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: frame table plus hand sequences for
// ACK back-pressure, timeout, re-sync while running and mid-frame reset.
module tb_uart_boot_loader;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int TMO     = 100;

  logic               clk = 1'b0;
  logic               reset;
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               tx_ready;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               cpu_hold;
  logic               boot_done;
  logic               boot_error;
  logic               busy;

  uart_boot_loader #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .HOLD_AT_RESET(1'b1), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .boot_done(boot_done), .boot_error(boot_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+INSTR_W-1:0] wq[$];

  always @(negedge clk) if (mem_we) wq.push_back({mem_addr, mem_wdata});

  typedef struct {
    logic [7:0]  b[10];
    int          n;
    int          nw;
    logic [7:0]  wa[2];
    logic [15:0] wd[2];
    logic [7:0]  code;
    logic        hold;
    logic        err;
    logic        done;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic run_vec(input int idx);
    int k;
    wq.delete();
    for (int i = 0; i < vecs[idx].n; i++) send_byte(vecs[idx].b[i]);
    k = 0;
    while (!tx_valid && k < 20) begin
      tick();
      k++;
    end
    chk($sformatf("v%0d_tx_valid", idx), tx_valid, 1);
    chk($sformatf("v%0d_tx_data", idx), tx_data, vecs[idx].code);
    chk($sformatf("v%0d_busy_in_ack", idx), busy, 1);
    tick();
    chk($sformatf("v%0d_tx_valid_drop", idx), tx_valid, 0);
    chk($sformatf("v%0d_busy_after", idx), busy, 0);
    chk($sformatf("v%0d_cpu_hold", idx), cpu_hold, vecs[idx].hold);
    chk($sformatf("v%0d_boot_error", idx), boot_error, vecs[idx].err);
    chk($sformatf("v%0d_boot_done", idx), boot_done, vecs[idx].done);
    tick();
    chk($sformatf("v%0d_boot_done_pulse", idx), boot_done, 0);
    chk($sformatf("v%0d_nwrites", idx), wq.size(), vecs[idx].nw);
    for (int i = 0; i < vecs[idx].nw && i < wq.size(); i++) begin
      chk($sformatf("v%0d_waddr%0d", idx, i), wq[i][ADDR_W+INSTR_W-1:INSTR_W], vecs[idx].wa[i]);
      chk($sformatf("v%0d_wdata%0d", idx, i), wq[i][INSTR_W-1:0], vecs[idx].wd[i]);
    end
  endtask

  initial begin
    int k;
    int nw_before;

    vecs[0] = '{b:'{8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h40,8'h00,8'h00,8'h00}, n:7, nw:2,
                wa:'{8'h00,8'h01}, wd:'{16'h1234,16'hABCD}, code:8'h06, hold:1'b0, err:1'b0, done:1'b1};
    vecs[1] = '{b:'{8'hA5,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h41,8'h00,8'h00,8'h00}, n:7, nw:2,
                wa:'{8'h00,8'h01}, wd:'{16'h1234,16'hABCD}, code:8'h15, hold:1'b1, err:1'b1, done:1'b0};
    vecs[2] = vecs[0];
    vecs[3] = '{b:'{8'h00,8'hFF,8'h5A,8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n:6, nw:0,
                wa:'{8'h00,8'h00}, wd:'{16'h0000,16'h0000}, code:8'h06, hold:1'b0, err:1'b0, done:1'b1};
    vecs[4] = '{b:'{8'hA5,8'h01,8'hBE,8'hEF,8'h51,8'h00,8'h00,8'h00,8'h00,8'h00}, n:5, nw:1,
                wa:'{8'h00,8'h00}, wd:'{16'hBEEF,16'h0000}, code:8'h06, hold:1'b0, err:1'b0, done:1'b1};

    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    tick(); tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_boot_error", boot_error, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) run_vec(v);

    // ACK back-pressure, write timing and a dropped A5 during ACK
    wq.delete();
    tx_ready = 1'b0;
    send_byte(8'hA5);
    chk("bp_hold_on_sync", cpu_hold, 1);
    send_byte(8'h01);
    send_byte(8'h12);
    chk("bp_no_we_mid_word", mem_we, 0);
    send_byte(8'h34);
    chk("bp_we_t1", mem_we, 1);
    chk("bp_addr", mem_addr, 8'h00);
    chk("bp_wdata", mem_wdata, 16'h1234);
    send_byte(8'h26);
    chk("bp_we_one_cycle", mem_we, 0);
    chk("bp_tx_valid_t1", tx_valid, 1);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) send_byte(8'hA5); else tick();
      chk($sformatf("bp_hold_valid_c%0d", i), tx_valid, 1);
      chk($sformatf("bp_hold_data_c%0d", i), tx_data, 8'h06);
      chk($sformatf("bp_hold_cpu_c%0d", i), cpu_hold, 1);
    end
    tx_ready = 1'b1;
    tick();
    chk("bp_release_valid", tx_valid, 0);
    chk("bp_release_hold", cpu_hold, 0);
    chk("bp_release_done", boot_done, 1);
    tick();
    chk("bp_a5_dropped", busy, 0);
    chk("bp_nwrites", wq.size(), 1);

    // Re-sync while the core runs
    send_byte(8'hA5);
    chk("resync_hold", cpu_hold, 1);
    chk("resync_busy", busy, 1);

    // Timeout after A5 02 12 (already sent A5)
    wq.delete();
    send_byte(8'h02);
    send_byte(8'h12);
    k = 1;
    while (!tx_valid && k < 300) begin
      tick();
      k++;
    end
    total++;
    if (k != TMO && k != TMO + 1) begin
      bad++;
      $display("FAIL tmo_latency: got %0d cycles expected %0d..%0d", k, TMO, TMO + 1);
    end
    chk("tmo_tx_data", tx_data, 8'h15);
    chk("tmo_boot_error", boot_error, 1);
    tick();
    chk("tmo_hold", cpu_hold, 1);
    chk("tmo_no_done", boot_done, 0);
    chk("tmo_nwrites", wq.size(), 0);

    // Reset asserted mid-DATA
    run_vec(0);
    wq.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    #2 reset = 1'b0;
    #1;
    chk("mrst_cpu_hold", cpu_hold, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_mem_addr", mem_addr, 0);
    chk("mrst_mem_wdata", mem_wdata, 0);
    chk("mrst_tx_data", tx_data, 0);
    chk("mrst_tx_valid", tx_valid, 0);
    chk("mrst_boot_error", boot_error, 0);
    nw_before = wq.size();
    send_byte(8'h78);
    tick();
    reset = 1'b1;
    send_byte(8'h78);
    send_byte(8'h9A);
    tick(); tick();
    chk("mrst_no_more_we", wq.size(), nw_before);
    chk("mrst_idle", busy, 0);
    chk("mrst_mem_we", mem_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
